// File: rtl/inst_mem_if.sv
// -----------------------------------------------------------------------------
// inst_mem_if
//   Request/response bundle between a fetch or load-store unit (master) and
//   inst_mem (slave). Clock and reset are not part of the bundle.
//
//   Signals
//     w_en, w_addr_i, w_data_i, w_strb_i   write request (byte address, lanes)
//     r_en, r_addr_i                        read request (byte address)
//     r_data_o, r_valid_o                   registered read response
//     err_o                                 registered bad-access flag
//     busy_o                                zero-fill in progress
//
//   DW must match the DW of the inst_mem instance it is connected to.
// -----------------------------------------------------------------------------
interface inst_mem_if #(
   parameter int DW = 32
);
   logic            w_en;
   logic [31:0]     w_addr_i;
   logic [DW-1:0]   w_data_i;
   logic [DW/8-1:0] w_strb_i;
   logic            r_en;
   logic [31:0]     r_addr_i;
   logic [DW-1:0]   r_data_o;
   logic            r_valid_o;
   logic            err_o;
   logic            busy_o;

   modport master (
      output w_en, w_addr_i, w_data_i, w_strb_i, r_en, r_addr_i,
      input  r_data_o, r_valid_o, err_o, busy_o
   );

   modport slave (
      input  w_en, w_addr_i, w_data_i, w_strb_i, r_en, r_addr_i,
      output r_data_o, r_valid_o, err_o, busy_o
   );
endinterface

// File: rtl/inst_mem.sv
// -----------------------------------------------------------------------------
// inst_mem
//   Single-clock, byte-addressed, word-organised memory shared by instruction
//   fetch and load/store. Per-byte write strobes, 1-cycle registered read with
//   a valid pulse, misaligned/out-of-range detection, optional zero-fill after
//   reset.
//
//   Ports
//     clk   rising-edge clock
//     rst   synchronous, active-low reset
//     bus   inst_mem_if.slave (write/read requests, read response, err, busy)
//
//   Parameters
//     DW          data width (multiple of 8)
//     AW          word-address width
//     MEM_NUM     number of words (<= 2**AW)
//     INIT_CLEAR  1: zero-fill the array after reset, 0: no fill
//
//   Build option
//     INST_MEM_BYPASS_EN  when defined, a read and a write to the same good
//                         word in one cycle return the strobe-merged data;
//                         otherwise the read returns the old contents.
// -----------------------------------------------------------------------------
module inst_mem #(
   parameter int DW         = 32,
   parameter int AW         = 12,
   parameter int MEM_NUM    = 4096,
   parameter int INIT_CLEAR = 1
) (
   input logic       clk,
   input logic       rst,
   inst_mem_if.slave bus
);

   localparam int NB = DW / 8;
   localparam int B  = (NB > 1) ? $clog2(NB) : 0;
   localparam int IW = (MEM_NUM > 1) ? $clog2(MEM_NUM) : 1;

   localparam logic [31:0] ALIGN_MASK = 32'((1 << B) - 1);
   localparam logic [AW:0] MEM_NUM_W  = (AW+1)'(MEM_NUM);
   localparam logic [AW:0] LAST_IDX   = (AW+1)'(MEM_NUM - 1);

   typedef enum logic {CLEAR, READY} init_state_e;

   init_state_e   state_q, state_d;
   logic [AW:0]   clr_cnt_q;   // one bit wider than AW so MEM_NUM = 2**AW cannot wrap
   logic          busy;
   logic          clr_we;

   logic [DW-1:0] mem [MEM_NUM];
   logic [DW-1:0] rd_word;

   logic [IW-1:0] w_idx, r_idx;
   logic          wr_req, wr_bad, wr_ok;
   logic          rd_req, rd_bad;

   logic [DW-1:0] r_data_q;
   logic          r_valid_q, err_q;

   // Bad = misaligned, word index beyond MEM_NUM, or any bit above the word
   // index set. For DW = 32 the word index is addr[AW+1:2].
   function automatic logic addr_bad(input logic [31:0] addr);
      logic [AW:0] idx;
      idx = {1'b0, addr[AW+B-1:B]};
      return (|(addr & ALIGN_MASK)) || (idx >= MEM_NUM_W) || (|addr[31:AW+B]);
   endfunction

   // ---------------------------------------------------------------- init FSM
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= (INIT_CLEAR != 0) ? CLEAR : READY;
         clr_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == CLEAR) clr_cnt_q <= clr_cnt_q + (AW+1)'(1);
      end
   end

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      if (state_q == CLEAR && clr_cnt_q == LAST_IDX) state_d = READY;
   end

   always_comb begin
      busy   = (state_q == CLEAR);
      clr_we = busy && rst;
   end

   // ---------------------------------------------------------- request decode
   // Requests seen while busy (or in a reset cycle) are dropped without a trace.
   assign w_idx  = bus.w_addr_i[IW+B-1:B];
   assign r_idx  = bus.r_addr_i[IW+B-1:B];
   assign wr_req = rst && bus.w_en && !busy;
   assign wr_bad = wr_req && addr_bad(bus.w_addr_i);
   assign wr_ok  = wr_req && !wr_bad;
   assign rd_req = rst && bus.r_en && !busy;
   assign rd_bad = addr_bad(bus.r_addr_i);

   // ------------------------------------------------------------ storage array
   // NOTE: the array itself has no reset; zero-fill walks it one word per cycle
   // so it maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem[clr_cnt_q[IW-1:0]] <= '0;
      end else if (wr_ok) begin
         for (int k = 0; k < NB; k++) begin
            if (bus.w_strb_i[k]) mem[w_idx][8*k +: 8] <= bus.w_data_i[8*k +: 8];
         end
      end
   end

   always_comb begin
      rd_word = mem[r_idx];
`ifdef INST_MEM_BYPASS_EN
      // Same-word collision: strobed lanes come from the incoming write.
      if (wr_ok && w_idx == r_idx) begin
         for (int k = 0; k < NB; k++) begin
            if (bus.w_strb_i[k]) rd_word[8*k +: 8] = bus.w_data_i[8*k +: 8];
         end
      end
`endif
   end

   // ---------------------------------------------------------- response stage
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_data_q  <= '0;
         r_valid_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         r_valid_q <= rd_req;
         err_q     <= (rd_req && rd_bad) || wr_bad;
         if (rd_req) r_data_q <= rd_bad ? '0 : rd_word;   // holds when idle
      end
   end

   assign bus.r_data_o  = r_data_q;
   assign bus.r_valid_o = r_valid_q;
   assign bus.err_o     = err_q;
   assign bus.busy_o    = busy;

endmodule
